// File: rtl/ucsbece154a_mem_arbiter_pkg.sv
// Shared definitions for the CPU/DMA memory arbiter.
//   arb_state_e : FSM encodings (IDLE / ACCESS)
//   OWNER_*     : owner codes reported on owner_o and used by the picker
//   cnt_width() : latency counter width, never narrower than 1 bit
package ucsbece154a_mem_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_ACCESS = 1'b1
  } arb_state_e;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DMA = 1'b1;

  function automatic int cnt_width(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/ucsbece154a_mem_arbiter_if.sv
// Requester-side memory port (one instance for the CPU, one for the DMA).
//   req/we/adr/wd : request, held by the requester until gnt is sampled high
//   gnt           : request accepted this edge (combinational)
//   done          : one-cycle completion pulse
//   rd            : registered read data, held until the next read completes
// master = requester, slave = arbiter.
interface ucsbece154a_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] wd;
  logic              gnt;
  logic              done;
  logic [DATA_W-1:0] rd;

  modport master (output req, we, adr, wd, input gnt, done, rd);
  modport slave  (input req, we, adr, wd, output gnt, done, rd);
endinterface

// File: rtl/ucsbece154a_mem_arbiter_pick.sv
// Winner selection for the memory arbiter (purely combinational).
//   cpu_req_i, dma_req_i : pending requests
//   last_owner_i         : owner of the most recent grant
//   any_req_o            : at least one request pending
//   winner_o             : OWNER_CPU / OWNER_DMA
// Build option ARB_ROUND_ROBIN_EN: contention goes to !last_owner instead of
// always to the CPU. An uncontested request always wins.
module ucsbece154a_arb_pick
  import ucsbece154a_mem_arbiter_pkg::*;
(
  input  logic cpu_req_i,
  input  logic dma_req_i,
  input  logic last_owner_i,
  output logic any_req_o,
  output logic winner_o
);

  assign any_req_o = cpu_req_i | dma_req_i;

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    if (cpu_req_i && dma_req_i) winner_o = ~last_owner_i;
    else if (dma_req_i)         winner_o = OWNER_DMA;
    else                        winner_o = OWNER_CPU;
  end
`else
  // Fixed priority: last_owner only matters in the round-robin build.
  logic unused_last_owner;
  assign unused_last_owner = last_owner_i;

  always_comb begin
    if (cpu_req_i)      winner_o = OWNER_CPU;
    else if (dma_req_i) winner_o = OWNER_DMA;
    else                winner_o = OWNER_CPU;
  end
`endif

endmodule

// File: rtl/ucsbece154a_mem_arbiter.sv
// Shares the unified multicycle-core memory between the CPU port and a
// DMA/loader port. Each transaction: grant in IDLE, MEM_LAT ACCESS cycles with
// latched adr/we/wd on the memory bus, then a done pulse (and read data for
// reads) to the owner.
//   clk, reset       : clock, asynchronous active-low reset
//   cpu, dma         : requester ports (slave modport)
//   mem_en_o/we_o    : memory access / write enable (ACCESS only)
//   mem_adr_o/wd_o   : latched address / write data (hold outside ACCESS)
//   mem_rd_i         : memory read data, valid in the last ACCESS cycle
//   busy_o, owner_o  : transaction in flight, current owner (0 CPU, 1 DMA)
// Build option ARB_ROUND_ROBIN_EN (see ucsbece154a_arb_pick).
module ucsbece154a_mem_arbiter
  import ucsbece154a_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  ucsbece154a_mem_arbiter_if.slave cpu,
  ucsbece154a_mem_arbiter_if.slave dma,
  output logic                     mem_en_o,
  output logic                     mem_we_o,
  output logic [ADDR_W-1:0]        mem_adr_o,
  output logic [DATA_W-1:0]        mem_wd_o,
  input  logic [DATA_W-1:0]        mem_rd_i,
  output logic                     busy_o,
  output logic                     owner_o
);

  localparam int CNT_W = cnt_width(MEM_LAT);

  if (MEM_LAT < 1) begin : g_lat_chk
    $error("ucsbece154a_mem_arbiter: MEM_LAT must be at least 1");
  end

  arb_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              owner_q, last_owner_q;
  logic [ADDR_W-1:0] adr_q;
  logic              we_q;
  logic [DATA_W-1:0] wd_q;
  logic [DATA_W-1:0] cpu_rd_q, dma_rd_q;
  logic              cpu_done_q, dma_done_q;
  logic              any_req, winner;

  ucsbece154a_arb_pick u_pick (
    .cpu_req_i    (cpu.req),
    .dma_req_i    (dma.req),
    .last_owner_i (last_owner_q),
    .any_req_o    (any_req),
    .winner_o     (winner)
  );

  // Grant is gated by reset so no output is ever high while reset is held.
  logic grant;
  assign grant   = reset && (state_q == ARB_IDLE) && any_req;
  assign cpu.gnt = grant && (winner == OWNER_CPU);
  assign dma.gnt = grant && (winner == OWNER_DMA);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ARB_IDLE;
      cnt_q        <= '0;
      owner_q      <= OWNER_CPU;
      last_owner_q <= OWNER_CPU;
      adr_q        <= '0;
      we_q         <= 1'b0;
      wd_q         <= '0;
      cpu_rd_q     <= '0;
      dma_rd_q     <= '0;
      cpu_done_q   <= 1'b0;
      dma_done_q   <= 1'b0;
    end else begin
      cpu_done_q <= 1'b0;
      dma_done_q <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (any_req) begin
            owner_q      <= winner;
            last_owner_q <= winner;
            adr_q        <= (winner == OWNER_DMA) ? dma.adr : cpu.adr;
            we_q         <= (winner == OWNER_DMA) ? dma.we  : cpu.we;
            wd_q         <= (winner == OWNER_DMA) ? dma.wd  : cpu.wd;
            cnt_q        <= CNT_W'(MEM_LAT - 1);
            state_q      <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            // Last access cycle: mem_rd_i is valid now; writes leave rd alone.
            if (!we_q) begin
              if (owner_q == OWNER_DMA) dma_rd_q <= mem_rd_i;
              else                      cpu_rd_q <= mem_rd_i;
            end
            if (owner_q == OWNER_DMA) dma_done_q <= 1'b1;
            else                      cpu_done_q <= 1'b1;
            state_q <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign busy_o    = (state_q == ARB_ACCESS);
  assign owner_o   = owner_q;
  assign mem_en_o  = busy_o;
  assign mem_we_o  = busy_o && we_q;
  assign mem_adr_o = adr_q;
  assign mem_wd_o  = wd_q;

  assign cpu.done = cpu_done_q;
  assign cpu.rd   = cpu_rd_q;
  assign dma.done = dma_done_q;
  assign dma.rd   = dma_rd_q;

endmodule

// File: tb/tb_ucsbece154a_mem_arbiter.sv
// Bench for ucsbece154a_mem_arbiter: three instances (MEM_LAT 1, 2, 3) share
// clk/reset; each sees a combinational memory whose contents are a fixed
// function of the address. Expected read data is queued at grant time and
// compared when the matching done pulse appears.
module tb_ucsbece154a_mem_arbiter;
  import ucsbece154a_mem_arbiter_pkg::*;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return (a * 32'h9E37) ^ 32'hC0DE_0000;
  endfunction

  ucsbece154a_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) cpu1 (), dma1 (), cpu2 (), dma2 (), cpu3 (), dma3 ();

  logic        men1, mwe1, busy1, own1, men2, mwe2, busy2, own2, men3, mwe3, busy3, own3;
  logic [31:0] madr1, mwd1, mrd1, madr2, mwd2, mrd2, madr3, mwd3, mrd3;
  assign mrd1 = mem_fn(madr1);
  assign mrd2 = mem_fn(madr2);
  assign mrd3 = mem_fn(madr3);

  ucsbece154a_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_lat1 (
    .clk(clk), .reset(reset), .cpu(cpu1), .dma(dma1), .mem_en_o(men1), .mem_we_o(mwe1),
    .mem_adr_o(madr1), .mem_wd_o(mwd1), .mem_rd_i(mrd1), .busy_o(busy1), .owner_o(own1));
  ucsbece154a_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u_lat2 (
    .clk(clk), .reset(reset), .cpu(cpu2), .dma(dma2), .mem_en_o(men2), .mem_we_o(mwe2),
    .mem_adr_o(madr2), .mem_wd_o(mwd2), .mem_rd_i(mrd2), .busy_o(busy2), .owner_o(own2));
  ucsbece154a_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_lat3 (
    .clk(clk), .reset(reset), .cpu(cpu3), .dma(dma3), .mem_en_o(men3), .mem_we_o(mwe3),
    .mem_adr_o(madr3), .mem_wd_o(mwd3), .mem_rd_i(mrd3), .busy_o(busy3), .owner_o(own3));

  logic [31:0] q_cpu1[$], q_dma1[$], q_cpu2[$], q_dma3[$];

  task automatic test_reset();
    cpu1.req = 1'b1; // gnt must stay low while reset is held
    repeat (2) @(negedge clk);
    checks++;
    if ({men1, mwe1, madr1, mwd1, busy1, own1, cpu1.gnt, cpu1.done, cpu1.rd, dma1.gnt, dma1.done, dma1.rd} !== '0)
      begin errors++; $display("FAIL reset_lat1: outputs not all zero (gnt=%b busy=%b)", cpu1.gnt, busy1); end
    checks++;
    if ({men2, mwe2, madr2, mwd2, busy2, own2, cpu2.gnt, cpu2.done, cpu2.rd, dma2.gnt, dma2.done, dma2.rd} !== '0)
      begin errors++; $display("FAIL reset_lat2: outputs not all zero"); end
    checks++;
    if ({men3, mwe3, madr3, mwd3, busy3, own3, cpu3.gnt, cpu3.done, cpu3.rd, dma3.gnt, dma3.done, dma3.rd} !== '0)
      begin errors++; $display("FAIL reset_lat3: outputs not all zero"); end
    cpu1.req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_write();
    cpu3.req = 1'b1; cpu3.we = 1'b1; cpu3.adr = 32'h80; cpu3.wd = 32'hA1A1;
    #1;
    checks++;
    if (cpu3.gnt !== 1'b1) begin errors++; $display("FAIL midwr_gnt: got %b expected 1", cpu3.gnt); end
    @(negedge clk);
    cpu3.req = 1'b0; cpu3.we = 1'b0;
    checks++;
    if (mwe3 !== 1'b1) begin errors++; $display("FAIL midwr_we_before: got %b expected 1", mwe3); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (mwe3 !== 1'b0) begin errors++; $display("FAIL midwr_we_abort: got %b expected 0", mwe3); end
    checks++;
    if ({men3, madr3, mwd3, busy3, own3, cpu3.gnt, cpu3.done, cpu3.rd, dma3.gnt, dma3.done, dma3.rd} !== '0)
      begin errors++; $display("FAIL midwr_outputs: en=%b adr=%h wd=%h busy=%b", men3, madr3, mwd3, busy3); end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (cpu3.done !== 1'b0 || busy3 !== 1'b0)
        begin errors++; $display("FAIL midwr_no_done: cyc %0d done=%b busy=%b expected 0", i, cpu3.done, busy3); end
    end
  endtask

  task automatic test_lone_cpu_read();
    cpu1.req = 1'b1; cpu1.we = 1'b0; cpu1.adr = 32'h10;
    #1;
    checks++;
    if (cpu1.gnt !== 1'b1 || dma1.gnt !== 1'b0)
      begin errors++; $display("FAIL lone_gnt: cpu=%b dma=%b expected 1/0", cpu1.gnt, dma1.gnt); end
    q_cpu1.push_back(mem_fn(32'h10));
    @(negedge clk);
    cpu1.req = 1'b0;
    checks++;
    if (men1 !== 1'b1 || mwe1 !== 1'b0 || madr1 !== 32'h10 || busy1 !== 1'b1 || own1 !== OWNER_CPU || cpu1.done !== 1'b0)
      begin errors++; $display("FAIL lone_access: en=%b we=%b adr=%h busy=%b own=%b", men1, mwe1, madr1, busy1, own1); end
    @(negedge clk);
    checks++;
    if (cpu1.done !== 1'b1) begin errors++; $display("FAIL lone_done: got %b expected 1", cpu1.done); end
    checks++;
    if (q_cpu1.size() == 0) begin errors++; $display("FAIL lone_sb: queue empty"); end
    else if (cpu1.rd !== q_cpu1.pop_front() || cpu1.rd !== 32'hDEADBEEF)
      begin errors++; $display("FAIL lone_rd: got %h expected deadbeef", cpu1.rd); end
    checks++;
    if (dma1.done !== 1'b0 || dma1.rd !== 32'h0 || dma1.gnt !== 1'b0 || men1 !== 1'b0)
      begin errors++; $display("FAIL lone_dma_quiet: done=%b rd=%h en=%b", dma1.done, dma1.rd, men1); end
    @(negedge clk);
    checks++;
    if (cpu1.done !== 1'b0) begin errors++; $display("FAIL lone_pulse: got %b expected 0", cpu1.done); end
  endtask

  task automatic test_dma_write();
    logic [31:0] last_rd;
    int lat;
    bit seen;
    // Read first so the "rd unchanged by write" check is against a nonzero value.
    dma3.req = 1'b1; dma3.we = 1'b0; dma3.adr = 32'h08;
    #1;
    checks++;
    if (dma3.gnt !== 1'b1) begin errors++; $display("FAIL dmard_gnt: got %b expected 1", dma3.gnt); end
    q_dma3.push_back(mem_fn(32'h08));
    @(negedge clk);
    dma3.req = 1'b0;
    lat = 1; seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (dma3.done) seen = 1'b1; else begin @(negedge clk); lat++; end
    end
    checks++;
    if (!seen || lat != 4) begin errors++; $display("FAIL dmard_latency: got %0d expected 4 (seen=%b)", lat, seen); end
    last_rd = q_dma3.size() ? q_dma3.pop_front() : 32'hx;
    checks++;
    if (dma3.rd !== last_rd) begin errors++; $display("FAIL dmard_rd: got %h expected %h", dma3.rd, last_rd); end
    // Write issued in the done cycle (IDLE).
    dma3.req = 1'b1; dma3.we = 1'b1; dma3.adr = 32'h40; dma3.wd = 32'h55AA;
    #1;
    checks++;
    if (dma3.gnt !== 1'b1 || cpu3.gnt !== 1'b0) begin errors++; $display("FAIL dmawr_gnt: got %b expected 1", dma3.gnt); end
    q_dma3.push_back(last_rd);
    @(negedge clk);
    dma3.req = 1'b0; dma3.we = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if (men3 !== 1'b1 || mwe3 !== 1'b1 || madr3 !== 32'h40 || mwd3 !== 32'h55AA || dma3.done !== 1'b0 || own3 !== OWNER_DMA)
        begin errors++; $display("FAIL dmawr_access%0d: en=%b we=%b adr=%h wd=%h done=%b", k, men3, mwe3, madr3, mwd3, dma3.done); end
      @(negedge clk);
    end
    checks++;
    if (dma3.done !== 1'b1 || mwe3 !== 1'b0) begin errors++; $display("FAIL dmawr_done: done=%b we=%b expected 1/0", dma3.done, mwe3); end
    last_rd = q_dma3.size() ? q_dma3.pop_front() : 32'hx;
    checks++;
    if (dma3.rd !== last_rd) begin errors++; $display("FAIL dmawr_rd_kept: got %h expected %h", dma3.rd, last_rd); end
    @(negedge clk);
  endtask

  task automatic test_contention();
    int grants = 0, ncpu = 0, ndma = 0;
    logic last = OWNER_CPU; // previous DUT1 grant went to the CPU
    logic exp;
    logic [31:0] e;
    cpu1.req = 1'b1; cpu1.we = 1'b0; cpu1.adr = 32'h20;
    dma1.req = 1'b1; dma1.we = 1'b0; dma1.adr = 32'h24;
    for (int cyc = 0; cyc < 60 && grants < 10; cyc++) begin
      #1;
      if (cpu1.done) begin
        ncpu++; e = q_cpu1.size() ? q_cpu1.pop_front() : 32'hx;
        checks++;
        if (cpu1.rd !== e) begin errors++; $display("FAIL cont_cpu_rd: got %h expected %h", cpu1.rd, e); end
      end
      if (dma1.done) begin
        ndma++; e = q_dma1.size() ? q_dma1.pop_front() : 32'hx;
        checks++;
        if (dma1.rd !== e) begin errors++; $display("FAIL cont_dma_rd: got %h expected %h", dma1.rd, e); end
      end
      if (cpu1.gnt || dma1.gnt) begin
        exp = RR ? ~last : OWNER_CPU;
        checks++;
        if ((cpu1.gnt && dma1.gnt) || dma1.gnt !== exp)
          begin errors++; $display("FAIL cont_grant%0d: cpu_gnt=%b dma_gnt=%b expected owner %b", grants, cpu1.gnt, dma1.gnt, exp); end
        last = dma1.gnt;
        if (dma1.gnt) q_dma1.push_back(mem_fn(32'h24)); else q_cpu1.push_back(mem_fn(32'h20));
        grants++;
      end
      @(negedge clk);
    end
    cpu1.req = 1'b0; dma1.req = 1'b0;
    checks++;
    if (grants != 10) begin errors++; $display("FAIL cont_timeout: got %0d grants expected 10", grants); end
    for (int i = 0; i < 4; i++) begin
      #1;
      if (cpu1.done) begin
        ncpu++; e = q_cpu1.size() ? q_cpu1.pop_front() : 32'hx;
        checks++;
        if (cpu1.rd !== e) begin errors++; $display("FAIL cont_cpu_rd_tail: got %h expected %h", cpu1.rd, e); end
      end
      if (dma1.done) begin
        ndma++; e = q_dma1.size() ? q_dma1.pop_front() : 32'hx;
        checks++;
        if (dma1.rd !== e) begin errors++; $display("FAIL cont_dma_rd_tail: got %h expected %h", dma1.rd, e); end
      end
      @(negedge clk);
    end
    checks++;
    if (ncpu != (RR ? 5 : 10) || ndma != (RR ? 5 : 0))
      begin errors++; $display("FAIL cont_done_count: cpu %0d dma %0d expected %0d/%0d", ncpu, ndma, RR ? 5 : 10, RR ? 5 : 0); end
    checks++;
    if (q_cpu1.size() != 0 || q_dma1.size() != 0)
      begin errors++; $display("FAIL cont_sb_left: cpu %0d dma %0d expected 0", q_cpu1.size(), q_dma1.size()); end
  endtask

  task automatic test_back_to_back();
    int ng = 0, prev = 0, ndone = 0;
    bit chg = 1'b0, dn;
    logic [31:0] e;
    cpu2.req = 1'b1; cpu2.we = 1'b0; cpu2.adr = 32'h100;
    for (int cyc = 0; cyc < 40 && ng < 4; cyc++) begin
      if (chg) begin cpu2.adr = 32'h100 + 32'(4 * ng); chg = 1'b0; end
      #1;
      dn = cpu2.done;
      if (dn) begin
        ndone++; e = q_cpu2.size() ? q_cpu2.pop_front() : 32'hx;
        checks++;
        if (cpu2.rd !== e) begin errors++; $display("FAIL b2b_rd: got %h expected %h", cpu2.rd, e); end
      end
      if (cpu2.gnt) begin
        q_cpu2.push_back(mem_fn(cpu2.adr));
        if (ng > 0) begin
          checks++;
          if (cyc - prev != 3) begin errors++; $display("FAIL b2b_spacing: got %0d expected 3", cyc - prev); end
          checks++;
          if (!dn) begin errors++; $display("FAIL b2b_gnt_with_done: done=%b expected 1", dn); end
        end
        prev = cyc; ng++; chg = 1'b1;
      end
      @(negedge clk);
    end
    cpu2.req = 1'b0;
    checks++;
    if (ng != 4) begin errors++; $display("FAIL b2b_timeout: got %0d grants expected 4", ng); end
    for (int i = 0; i < 5; i++) begin
      #1;
      if (cpu2.done) begin
        ndone++; e = q_cpu2.size() ? q_cpu2.pop_front() : 32'hx;
        checks++;
        if (cpu2.rd !== e) begin errors++; $display("FAIL b2b_rd_tail: got %h expected %h", cpu2.rd, e); end
      end
      @(negedge clk);
    end
    checks++;
    if (ndone != 4 || q_cpu2.size() != 0) begin errors++; $display("FAIL b2b_done_count: got %0d expected 4", ndone); end
  endtask

  initial begin
    cpu1.req = 0; cpu1.we = 0; cpu1.adr = 0; cpu1.wd = 0;
    dma1.req = 0; dma1.we = 0; dma1.adr = 0; dma1.wd = 0;
    cpu2.req = 0; cpu2.we = 0; cpu2.adr = 0; cpu2.wd = 0;
    dma2.req = 0; dma2.we = 0; dma2.adr = 0; dma2.wd = 0;
    cpu3.req = 0; cpu3.we = 0; cpu3.adr = 0; cpu3.wd = 0;
    dma3.req = 0; dma3.we = 0; dma3.adr = 0; dma3.wd = 0;
    @(negedge clk);
    test_reset();
    test_reset_mid_write();
    test_lone_cpu_read();
    test_dma_write();
    test_contention();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
